// File: rtl/pkg_salsa.sv
// Shared constants, FSM state type and state-word layout
// for the Salsa20 block-state initialiser.
package pkg_salsa;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // "expand 32-byte k" and "expand 16-byte k", word 0 in [31:0]
  localparam logic [3:0][31:0] SIGMA = {
    32'h6b206574, 32'h79622d32,
    32'h3320646e, 32'h61707865
  };
  localparam logic [3:0][31:0] TAU = {
    32'h6b206574, 32'h79622d36,
    32'h3120646e, 32'h61707865
  };

  localparam logic [3:0] IDX_C0     = 4'd0;
  localparam logic [3:0] IDX_K0     = 4'd1;
  localparam logic [3:0] IDX_C1     = 4'd5;
  localparam logic [3:0] IDX_N0     = 4'd6;
  localparam logic [3:0] IDX_CTR_LO = 4'd8;
  localparam logic [3:0] IDX_CTR_HI = 4'd9;
  localparam logic [3:0] IDX_C2     = 4'd10;
  localparam logic [3:0] IDX_KH     = 4'd11;
  localparam logic [3:0] IDX_C3     = 4'd15;

  localparam logic [3:0] ADDR_CTR_LO = 4'd10;
  localparam logic [3:0] ADDR_CTR_HI = 4'd11;

  function automatic logic [3:0][31:0] consts(
    input logic key_len
  );
    return key_len ? SIGMA : TAU;
  endfunction

endpackage

// File: rtl/salsa_matrix_pack.sv
// Combinational assembly of the 4x4 Salsa20 input matrix
// from constants, key, nonce and 64-bit block counter.
module salsa_matrix_pack
  import pkg_salsa::*;
(
  input  logic [7:0][31:0] key_i,
  input  logic [1:0][31:0] nonce_i,
  input  logic [63:0]      ctr_i,
  input  logic             key_len_i,
  output logic [511:0]     state_o
);

  logic [15:0][31:0] m;
  logic [3:0][31:0]  c;

  always_comb begin
    m = '0;
    c = consts(key_len_i);
    m[IDX_C0] = c[0];
    m[IDX_C1] = c[1];
    m[IDX_C2] = c[2];
    m[IDX_C3] = c[3];
    for (int i = 0; i < 4; i++) begin
      m[IDX_K0 + 4'(i)] = key_i[3'(i)];
      // 16-byte keys repeat the low half
      m[IDX_KH + 4'(i)] = key_len_i ? key_i[3'(i + 4)]
                                    : key_i[3'(i)];
    end
    m[IDX_N0]         = nonce_i[0];
    m[IDX_N0 + 4'd1]  = nonce_i[1];
    m[IDX_CTR_LO]     = ctr_i[31:0];
    m[IDX_CTR_HI]     = ctr_i[63:32];
    state_o = m;
  end

endmodule

// File: rtl/salsa_state_init.sv
// Loads key/nonce/counter words and streams one Salsa20
// input matrix per accepted block, advancing the counter.
module salsa_state_init
  import pkg_salsa::*;
#(
  parameter int NB_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_len,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [31:0]     wr_data,
  input  logic            start,
  input  logic [NB_W-1:0] num_blocks,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [511:0]    out_state,
  output logic            done,
  output logic            ctr_wrap
);

  state_e            state_q;
  logic [7:0][31:0]  key_q;
  logic [1:0][31:0]  nonce_q;
  logic [63:0]       ctr_q;
  logic              wrap_q;
  logic              keylen_q;
  logic [NB_W-1:0]   remain_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [511:0]      matrix;
  logic              hs;

  assign hs = valid_q && out_ready;

  salsa_matrix_pack u_pack (
    .key_i     (key_q),
    .nonce_i   (nonce_q),
    .ctr_i     (ctr_q),
    .key_len_i (keylen_q),
    .state_o   (matrix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      nonce_q  <= '0;
      ctr_q    <= '0;
      wrap_q   <= 1'b0;
      keylen_q <= 1'b0;
      remain_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (wr_en) begin
            if (!wr_addr[3]) begin
              key_q[wr_addr[2:0]] <= wr_data;
            end else if (wr_addr[3:1] == 3'b100) begin
              nonce_q[wr_addr[0]] <= wr_data;
            end else if (wr_addr == ADDR_CTR_LO) begin
              ctr_q[31:0] <= wr_data;
            end else if (wr_addr == ADDR_CTR_HI) begin
              ctr_q[63:32] <= wr_data;
              wrap_q       <= 1'b0;
            end
          end
          if (start) begin
            keylen_q <= key_len;
            if (num_blocks != '0) begin
              state_q  <= ST_RUN;
              remain_q <= num_blocks;
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            ctr_q    <= ctr_q + 64'd1;
            remain_q <= remain_q - NB_W'(1);
            if (ctr_q == '1) wrap_q <= 1'b1;
            if (remain_q == NB_W'(1)) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // registers are frozen outside IDLE, so gating holds it stable
  assign out_state = valid_q ? matrix : '0;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ctr_wrap  = wrap_q;

endmodule

// File: tb/tb_salsa_state_init.sv
// Directed self-checking bench for salsa_state_init.
module tb_salsa_state_init;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_len = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         start = 1'b0;
  logic [15:0]  num_blocks = '0;
  logic         busy;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_state;
  logic         done;
  logic         ctr_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  salsa_state_init #(.NB_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_len    (key_len),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .num_blocks (num_blocks),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .done       (done),
    .ctr_wrap   (ctr_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int i);
    return out_state[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_key();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] v;
      v = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      wr(4'(k), v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
        ctr_wrap !== 1'b0 || out_state !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b valid=%b done=%b wrap=%b st_nz=%b",
               busy, out_valid, done, ctr_wrap, |out_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_key32();
    int dcnt;
    load_key();
    out_ready = 1'b1; key_len = 1'b1;
    start = 1'b1; num_blocks = 16'd1;
    tick();
    start = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL key32_valid: valid=%b busy=%b exp 1 1",
               out_valid, busy);
    end
    n_tests++;
    if (w(0) !== 32'h61707865 || w(1) !== 32'h03020100 ||
        w(8) !== 32'h0 || w(11) !== 32'h13121110) begin
      n_fail++;
      $display("FAIL key32_words: w0=%h w1=%h w8=%h w11=%h exp 61707865 03020100 0 13121110",
               w(0), w(1), w(8), w(11));
    end
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    n_tests++;
    if (dcnt != 1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL key32_done: pulses=%0d valid=%b exp 1 0",
               dcnt, out_valid);
    end
  endtask

  task automatic test_key16();
    key_len = 1'b0;
    start = 1'b1; num_blocks = 16'd1;
    tick();
    start = 1'b0;
    n_tests++;
    if (w(5) !== 32'h3120646e || w(10) !== 32'h79622d36 ||
        w(11) !== 32'h03020100 || w(14) !== 32'h0f0e0d0c) begin
      n_fail++;
      $display("FAIL key16_words: w5=%h w10=%h w11=%h w14=%h exp 3120646e 79622d36 03020100 0f0e0d0c",
               w(5), w(10), w(11), w(14));
    end
    n_tests++;
    if (w(8) !== 32'h1) begin
      n_fail++;
      $display("FAIL key16_ctr_retained: w8=%h exp 1", w(8));
    end
    tick(); tick();
  endtask

  task automatic test_burst();
    wr(4'd10, 32'h0);
    wr(4'd11, 32'h0);
    key_len = 1'b1; out_ready = 1'b1;
    start = 1'b1; num_blocks = 16'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || w(8) !== 32'(i)) begin
        n_fail++;
        $display("FAIL burst_blk%0d: valid=%b w8=%h exp 1 %h",
                 i, out_valid, w(8), 32'(i));
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_end: valid=%b done=%b busy=%b exp 0 1 0",
               out_valid, done, busy);
    end
    tick();
    start = 1'b1; num_blocks = 16'd1;
    tick();
    start = 1'b0;
    n_tests++;
    if (w(8) !== 32'h4) begin
      n_fail++;
      $display("FAIL burst_next_run: w8=%h exp 4", w(8));
    end
    tick(); tick();
  endtask

  task automatic test_wrap();
    wr(4'd10, 32'hffffffff);
    wr(4'd11, 32'hffffffff);
    out_ready = 1'b1;
    start = 1'b1; num_blocks = 16'd2;
    tick();
    start = 1'b0;
    n_tests++;
    if (w(8) !== 32'hffffffff || w(9) !== 32'hffffffff ||
        ctr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_first: w8=%h w9=%h wrap=%b exp ffffffff ffffffff 0",
               w(8), w(9), ctr_wrap);
    end
    tick();
    n_tests++;
    if (w(8) !== 32'h0 || w(9) !== 32'h0 || ctr_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_second: w8=%h w9=%h wrap=%b exp 0 0 1",
               w(8), w(9), ctr_wrap);
    end
    tick(); tick(); tick();
    n_tests++;
    if (ctr_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_sticky: wrap=%b exp 1", ctr_wrap);
    end
    wr(4'd10, 32'h5);
    n_tests++;
    if (ctr_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_lo_write: wrap=%b exp 1", ctr_wrap);
    end
    wr(4'd11, 32'h0);
    n_tests++;
    if (ctr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clear: wrap=%b exp 0", ctr_wrap);
    end
  endtask

  task automatic test_stall();
    wr(4'd10, 32'h100);
    wr(4'd11, 32'h0);
    out_ready = 1'b0;
    start = 1'b1; num_blocks = 16'd3;
    tick();
    start = 1'b0;
    // writes during RUN must be dropped
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hdeadbeef;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || w(8) !== 32'h100 ||
          w(1) !== 32'h03020100 || w(0) !== 32'h61707865) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: valid=%b w8=%h w1=%h w0=%h exp 1 100 03020100 61707865",
                 i, out_valid, w(8), w(1), w(0));
      end
      tick();
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (w(8) !== 32'h101 || w(1) !== 32'h03020100) begin
      n_fail++;
      $display("FAIL stall_resume: w8=%h w1=%h exp 101 03020100",
               w(8), w(1));
    end
    tick();
    n_tests++;
    if (w(8) !== 32'h102) begin
      n_fail++;
      $display("FAIL stall_last: w8=%h exp 102", w(8));
    end
    tick(); tick();
  endtask

  task automatic test_coincide_and_zero();
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'haabbccdd;
    start = 1'b1; num_blocks = 16'd1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || w(6) !== 32'haabbccdd) begin
      n_fail++;
      $display("FAIL coincide_write: valid=%b w6=%h exp 1 aabbccdd",
               out_valid, w(6));
    end
    tick(); tick();
    start = 1'b1; num_blocks = 16'd0;
    tick();
    start = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_blocks: valid=%b done=%b busy=%b exp 0 1 0",
               out_valid, done, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_len: done=%b exp 0", done);
    end
  endtask

  task automatic test_reset_midrun();
    int dcnt;
    out_ready = 1'b1;
    start = 1'b1; num_blocks = 16'd6;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_state !== '0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b busy=%b st_nz=%b exp 0 0 0",
               out_valid, busy, |out_state);
    end
    tick();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    n_tests++;
    if (dcnt != 0) begin
      n_fail++;
      $display("FAIL rst_no_done: pulses=%0d exp 0", dcnt);
    end
    key_len = 1'b1;
    start = 1'b1; num_blocks = 16'd1;
    tick();
    start = 1'b0;
    n_tests++;
    if (w(8) !== 32'h0 || w(9) !== 32'h0 || w(1) !== 32'h0 ||
        w(6) !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_cleared: w8=%h w9=%h w1=%h w6=%h exp 0 0 0 0",
               w(8), w(9), w(1), w(6));
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_key32();
    test_key16();
    test_burst();
    test_wrap();
    test_stall();
    test_coincide_and_zero();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1);
  end

endmodule
